// File: rtl/nes_poll_engine.sv
// Polls NES/SNES pads: latch pulse, NUM_BITS shift clocks, inverted serial capture, one valid pulse per poll.
// Poll length 2*DIV*(1+NUM_BITS)+1 cycles; no backpressure, and a trigger that arrives while busy is dropped.
module nes_poll_engine #(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int DIV         = 6,
  parameter int POLL_PERIOD = 10000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         trigger,
  input  logic [NUM_PADS-1:0]          nesData,
  output logic                         nesLatch,
  output logic                         nesClk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic                         busy
);

  localparam int TW = (2*DIV > 2) ? $clog2(2*DIV) : 1;
  localparam int IW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam int PW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [TW-1:0] LATCH_LAST = TW'(2*DIV-1);
  localparam logic [TW-1:0] PHASE_LAST = TW'(DIV-1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BITS-1);
  localparam logic [PW-1:0] PER_LAST   = PW'(POLL_PERIOD-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t                             state_q, state_d;
  logic [TW-1:0]                      tick_q, tick_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [PW-1:0]                      period_q, period_d;
  logic [NUM_PADS-1:0]                sync1_q, sync2_q;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift_q, shift_d;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  buttons_q;
  logic                               nes_latch_q, nes_clk_q, valid_q, busy_q;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    period_d = (period_q == PER_LAST) ? period_q : period_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (trigger || (enable && (period_q == PER_LAST))) begin
          state_d  = S_LATCH;
          tick_d   = '0;
          period_d = '0;
        end
      end
      S_LATCH: begin
        if (tick_q == LATCH_LAST) begin
          state_d = S_LOW;
          tick_d  = '0;
          idx_d   = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_LOW: begin
        if (tick_q == PHASE_LAST) begin
          state_d = S_HIGH;
          tick_d  = '0;
          // Pads drive active-low; store 1 = pressed.
          for (int p = 0; p < NUM_PADS; p++) begin
            shift_d[p][idx_q] = ~sync2_q[p];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (tick_q == PHASE_LAST) begin
          tick_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so every pin comes straight off a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      idx_q       <= '0;
      period_q    <= PER_LAST;
      sync1_q     <= '0;
      sync2_q     <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      nes_latch_q <= 1'b0;
      nes_clk_q   <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      period_q    <= period_d;
      sync1_q     <= nesData;
      sync2_q     <= sync1_q;
      shift_q     <= shift_d;
      nes_latch_q <= (state_d == S_LATCH);
      nes_clk_q   <= (state_d != S_LOW);
      valid_q     <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      if (state_d == S_DONE) begin
        buttons_q <= shift_q;
      end
    end
  end

  assign nesLatch = nes_latch_q;
  assign nesClk   = nes_clk_q;
  assign buttons  = buttons_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_nes_poll_engine.sv
// Scoreboard bench: a behavioural 4021-style pad model supplies serial data and queues expected buttons; a monitor checks timing and results.
module tb_nes_poll_engine;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int DV = 4;
  localparam int PP = 200;
  localparam int L  = 2*DV*(1+NB)+1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic trigger = 1'b0;
  logic [NP-1:0] nesData;
  logic nesLatch, nesClk, valid, busy;
  logic [NP*NB-1:0] buttons;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nvalid = 0;

  logic [NP*NB-1:0] exp_q[$];
  int rise_q[$];
  logic [NB-1:0] pad_btn [NP];

  nes_poll_engine #(
    .NUM_PADS(NP), .NUM_BITS(NB), .DIV(DV), .POLL_PERIOD(PP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .nesData(nesData), .nesLatch(nesLatch), .nesClk(nesClk),
    .buttons(buttons), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Pad model: parallel load while latched, advance one bit on each rising shift clock.
  initial begin
    logic [NB-1:0] shadow [NP];
    int pidx;
    logic lat_prev, nclk_prev;
    pidx = NB;
    lat_prev = 1'b0;
    nclk_prev = 1'b1;
    for (int p = 0; p < NP; p++) shadow[p] = '0;
    forever begin
      @(negedge clk);
      if (nesLatch === 1'b1) begin
        pidx = 0;
        for (int p = 0; p < NP; p++) shadow[p] = pad_btn[p];
        lat_prev = 1'b1;
      end else begin
        if (lat_prev) exp_q.push_back({shadow[1], shadow[0]});
        lat_prev = 1'b0;
        if (nesClk === 1'b1 && nclk_prev === 1'b0 && pidx < NB) pidx++;
      end
      nclk_prev = nesClk;
      for (int p = 0; p < NP; p++) nesData[p] = (pidx < NB) ? ~shadow[p][pidx] : 1'b0;
    end
  end

  // Monitor: latch/clock timing, latency, and buttons against the scoreboard.
  initial begin
    int last_rise, lat_w, clk_w, pulses;
    logic lat_p, nclk_p, val_p, rst_p;
    logic [NP*NB-1:0] held;
    last_rise = -1000; lat_w = 0; clk_w = 0; pulses = 0;
    lat_p = 1'b0; nclk_p = 1'b1; val_p = 1'b0; rst_p = 1'b1; held = '0;
    forever begin
      @(negedge clk);
      if (rst_p) begin
        held = '0; lat_w = 0; clk_w = 0; pulses = 0;
        lat_p = 1'b0; nclk_p = 1'b1; val_p = 1'b0;
      end else begin
        if (nesLatch && !lat_p) begin
          chk("latch_rise_scheduled", rise_q.size() > 0, 1'b1);
          if (rise_q.size() > 0) chk("latch_rise_cycle", cyc, rise_q.pop_front());
          last_rise = cyc; lat_w = 0; pulses = 0;
        end
        if (nesLatch) lat_w++;
        if (!nesLatch && lat_p) chk("latch_width", lat_w, 2*DV);
        if (!nesClk && nclk_p) clk_w = 0;
        if (!nesClk) clk_w++;
        if (nesClk && !nclk_p) begin
          chk("clk_low_width", clk_w, DV);
          pulses++;
        end
        if (valid) begin
          nvalid++;
          chk("valid_latency", cyc - last_rise + 1, L);
          chk("clk_pulses", pulses, NB);
          chk("busy_at_valid", busy, 1'b1);
          chk("expected_queued", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            held = exp_q.pop_front();
            chk("buttons", buttons, held);
          end
        end else begin
          chk("buttons_hold", buttons, held);
        end
        if (val_p) chk("valid_one_cycle", valid, 1'b0);
        lat_p = nesLatch; nclk_p = nesClk; val_p = valid;
      end
      rst_p = reset;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int target, input int limit);
    int i = 0;
    while (nvalid < target && i < limit) begin
      step();
      i++;
    end
    chk("valid_timeout", nvalid >= target, 1'b1);
  endtask

  task automatic wait_latch(input int limit);
    int i = 0;
    while (nesLatch !== 1'b1 && i < limit) begin
      step();
      i++;
    end
    chk("latch_timeout", nesLatch, 1'b1);
  endtask

  task automatic wait_clk_edges(input bit rising, input int count, input int limit);
    int n = 0;
    int i = 0;
    logic prev;
    prev = nesClk;
    while (n < count && i < limit) begin
      step();
      i++;
      if (rising ? (nesClk && !prev) : (!nesClk && prev)) n++;
      prev = nesClk;
    end
    chk("clk_edge_timeout", n, count);
  endtask

  task automatic randomize_pads();
    for (int p = 0; p < NP; p++) pad_btn[p] = NB'($urandom);
  endtask

  task automatic pulse_trigger_expect_poll();
    rise_q.push_back(cyc + 1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  initial begin
    int r, n, v0, gap, off;
    pad_btn[0] = 8'h89;
    pad_btn[1] = 8'h00;
    reset = 1'b1;
    enable = 1'b1;
    trigger = 1'b0;
    repeat (4) step();
    chk("rst_latch", nesLatch, 1'b0);
    chk("rst_clk", nesClk, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_buttons", buttons, 16'h0000);

    // Auto mode out of reset, with a coincident trigger that must not add a poll.
    reset = 1'b0;
    trigger = 1'b1;
    r = cyc;
    for (int k = 0; k < 4; k++) rise_q.push_back(r + 1 + k*PP);
    step();
    trigger = 1'b0;
    wait_valid(1, 300);
    chk("first_poll_buttons", buttons, 16'h0089);
    randomize_pads();
    wait_valid(2, 300);
    randomize_pads();
    wait_valid(3, 300);
    randomize_pads();
    wait_latch(300);
    enable = 1'b0;
    wait_valid(4, 200);
    n = 0;
    repeat (1000) begin
      step();
      if (nesLatch) n++;
    end
    chk("latch_idle_after_disable", n, 0);

    // Second trigger during LOW of bit 3 is ignored.
    randomize_pads();
    v0 = nvalid;
    pulse_trigger_expect_poll();
    wait_latch(20);
    wait_clk_edges(1'b0, 4, 200);
    chk("in_low_phase", nesClk, 1'b0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    wait_valid(v0 + 1, 200);
    repeat (300) step();
    chk("one_poll_for_two_triggers", nvalid, v0 + 1);

    // Random patterns, random idle gaps, random ignored triggers mid-poll.
    for (int it = 0; it < 6; it++) begin
      randomize_pads();
      gap = $urandom_range(0, 20);
      repeat (gap) step();
      chk("busy_idle", busy, 1'b0);
      v0 = nvalid;
      pulse_trigger_expect_poll();
      off = $urandom_range(0, L - 10);
      repeat (off) step();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      wait_valid(v0 + 1, 200);
      step();
    end

    // Reset during HIGH of bit 5 aborts the poll.
    randomize_pads();
    v0 = nvalid;
    pulse_trigger_expect_poll();
    wait_latch(20);
    wait_clk_edges(1'b1, 6, 200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("abort_latch", nesLatch, 1'b0);
    chk("abort_clk", nesClk, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_buttons", buttons, 16'h0000);
    chk("abort_valid", valid, 1'b0);
    repeat (300) step();
    chk("abort_no_valid", nvalid, v0);

    // Recovery poll after the abort.
    randomize_pads();
    pulse_trigger_expect_poll();
    wait_valid(v0 + 1, 200);
    repeat (5) step();
    chk("rise_queue_drained", rise_q.size(), 0);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
